// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: Tuse/Tnew data-hazard detection,
// mult/div busy timer, and a saturating stall-cycle performance counter.
module hazard_stall_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs_ID,
    input  logic [4:0]       Rt_ID,
    input  logic [1:0]       Tuse_Rs,
    input  logic [1:0]       Tuse_Rt,
    input  logic             Md_ID,
    input  logic [4:0]       A3_EX,
    input  logic [1:0]       Tnew_EX,
    input  logic [4:0]       A3_MEM,
    input  logic [1:0]       Tnew_MEM,
    input  logic             Start_EX,
    input  logic             Md_Op_EX,
    output logic             En_PC,
    output logic             En_IF_ID,
    output logic             Clr_ID_EX,
    output logic             Busy,
    output logic [CNT_W-1:0] Stall_Cnt
);

    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned TW      = $clog2(MAX_CYC + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic stall_rs, stall_rt, stall_md, stall;

    // Operand hazard: a producer in EX/MEM won't have its result ready by the time ID needs it
    always_comb begin
        stall_rs = (Rs_ID != 5'd0) && (Tuse_Rs != 2'd3) &&
                   (((Rs_ID == A3_EX)  && (Tnew_EX  > Tuse_Rs)) ||
                    ((Rs_ID == A3_MEM) && (Tnew_MEM > Tuse_Rs)));
        stall_rt = (Rt_ID != 5'd0) && (Tuse_Rt != 2'd3) &&
                   (((Rt_ID == A3_EX)  && (Tnew_EX  > Tuse_Rt)) ||
                    ((Rt_ID == A3_MEM) && (Tnew_MEM > Tuse_Rt)));
        stall_md = Md_ID && ((state_q == BUSY) || Start_EX);
        stall    = stall_rs || stall_rt || stall_md;
    end

    assign En_PC     = ~stall;
    assign En_IF_ID  = ~stall;
    assign Clr_ID_EX = stall;
    assign Busy      = (state_q == BUSY);
    assign Stall_Cnt = cnt_q;

    // Busy timer: a new start is only accepted from IDLE
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        case (state_q)
            IDLE: begin
                if (Start_EX) begin
                    tmr_d   = Md_Op_EX ? TW'(DIV_CYCLES) : TW'(MULT_CYCLES);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (tmr_q == TW'(1)) begin
                    tmr_d   = '0;
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            default: begin
                tmr_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: one task per scenario, expected values hand-derived.
// A second instance with a 4-bit counter shares all inputs to exercise saturation.
module tb_hazard_stall_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  Rs_ID, Rt_ID, A3_EX, A3_MEM;
    logic [1:0]  Tuse_Rs, Tuse_Rt, Tnew_EX, Tnew_MEM;
    logic        Md_ID, Start_EX, Md_Op_EX;
    logic        En_PC, En_IF_ID, Clr_ID_EX, Busy;
    logic [31:0] Stall_Cnt;
    logic        s_en_pc, s_en_if_id, s_clr, s_busy;
    logic [3:0]  s_cnt;

    int unsigned chk_total;
    int unsigned chk_pass;
    int unsigned exp_cnt;

    hazard_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID),
        .Tuse_Rs(Tuse_Rs), .Tuse_Rt(Tuse_Rt), .Md_ID(Md_ID),
        .A3_EX(A3_EX), .Tnew_EX(Tnew_EX), .A3_MEM(A3_MEM), .Tnew_MEM(Tnew_MEM),
        .Start_EX(Start_EX), .Md_Op_EX(Md_Op_EX),
        .En_PC(En_PC), .En_IF_ID(En_IF_ID), .Clr_ID_EX(Clr_ID_EX),
        .Busy(Busy), .Stall_Cnt(Stall_Cnt)
    );

    hazard_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID),
        .Tuse_Rs(Tuse_Rs), .Tuse_Rt(Tuse_Rt), .Md_ID(Md_ID),
        .A3_EX(A3_EX), .Tnew_EX(Tnew_EX), .A3_MEM(A3_MEM), .Tnew_MEM(Tnew_MEM),
        .Start_EX(Start_EX), .Md_Op_EX(Md_Op_EX),
        .En_PC(s_en_pc), .En_IF_ID(s_en_if_id), .Clr_ID_EX(s_clr),
        .Busy(s_busy), .Stall_Cnt(s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        Rs_ID = 5'd0; Rt_ID = 5'd0; Tuse_Rs = 2'd3; Tuse_Rt = 2'd3; Md_ID = 1'b0;
        A3_EX = 5'd0; Tnew_EX = 2'd0; A3_MEM = 5'd0; Tnew_MEM = 2'd0;
        Start_EX = 1'b0; Md_Op_EX = 1'b0;
    endtask

    // Advance one clock; the bench tracks whether the elapsed cycle was a stall
    task automatic tick(input bit stalled);
        if (stalled) exp_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        #2;
        chk_total++; if (Busy !== 1'b0) $display("FAIL reset_busy got %0b exp 0", Busy); else chk_pass++;
        chk_total++; if (Stall_Cnt !== 32'd0) $display("FAIL reset_cnt got %0d exp 0", Stall_Cnt); else chk_pass++;
        chk_total++; if (En_PC !== 1'b1 || Clr_ID_EX !== 1'b0)
            $display("FAIL reset_stall got en_pc=%0b clr=%0b exp 1/0", En_PC, Clr_ID_EX); else chk_pass++;
        @(negedge clk);
        reset = 1'b1;
        exp_cnt = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_load_use();
        A3_EX = 5'd8; Tnew_EX = 2'd2; Rs_ID = 5'd8; Tuse_Rs = 2'd1;
        #1;
        chk_total++; if (En_PC !== 1'b0 || En_IF_ID !== 1'b0 || Clr_ID_EX !== 1'b1)
            $display("FAIL load_use_stall got %0b%0b%0b exp 001", En_PC, En_IF_ID, Clr_ID_EX); else chk_pass++;
        tick(1);
        Tnew_EX = 2'd1;
        #1;
        chk_total++; if (En_PC !== 1'b1 || En_IF_ID !== 1'b1 || Clr_ID_EX !== 1'b0)
            $display("FAIL load_use_release got %0b%0b%0b exp 110", En_PC, En_IF_ID, Clr_ID_EX); else chk_pass++;
        chk_total++; if (Stall_Cnt !== 32'd1) $display("FAIL load_use_cnt got %0d exp 1", Stall_Cnt); else chk_pass++;
        tick(0);
        clear_inputs();
    endtask

    task automatic test_zero_unused();
        Rs_ID = 5'd0; A3_EX = 5'd0; Tnew_EX = 2'd2; Tuse_Rs = 2'd0;
        #1;
        chk_total++; if (Clr_ID_EX !== 1'b0) $display("FAIL zero_reg got clr=%0b exp 0", Clr_ID_EX); else chk_pass++;
        tick(0);
        clear_inputs();
        Rt_ID = 5'd9; A3_MEM = 5'd9; Tnew_MEM = 2'd1; Tuse_Rt = 2'd3;
        #1;
        chk_total++; if (Clr_ID_EX !== 1'b0) $display("FAIL unused_rt got clr=%0b exp 0", Clr_ID_EX); else chk_pass++;
        tick(0);
        clear_inputs();
    endtask

    task automatic test_mem_hazard();
        Rt_ID = 5'd4; A3_MEM = 5'd4; Tnew_MEM = 2'd1; Tuse_Rt = 2'd0;
        #1;
        chk_total++; if (Clr_ID_EX !== 1'b1 || En_PC !== 1'b0)
            $display("FAIL mem_rt_stall got clr=%0b en=%0b exp 1/0", Clr_ID_EX, En_PC); else chk_pass++;
        tick(1);
        Tuse_Rt = 2'd1;
        #1;
        chk_total++; if (Clr_ID_EX !== 1'b0) $display("FAIL mem_rt_equal got clr=%0b exp 0", Clr_ID_EX); else chk_pass++;
        tick(0);
        clear_inputs();
        Rs_ID = 5'd5; A3_MEM = 5'd5; Tnew_MEM = 2'd2; Tuse_Rs = 2'd1;
        #1;
        chk_total++; if (En_IF_ID !== 1'b0) $display("FAIL mem_rs_stall got en_if_id=%0b exp 0", En_IF_ID); else chk_pass++;
        tick(1);
        clear_inputs();
        Rt_ID = 5'd7; A3_EX = 5'd7; Tnew_EX = 2'd3; Tuse_Rt = 2'd2;
        #1;
        chk_total++; if (Clr_ID_EX !== 1'b1) $display("FAIL ex_rt_stall got clr=%0b exp 1", Clr_ID_EX); else chk_pass++;
        tick(1);
        clear_inputs();
        #1;
        chk_total++; if (Stall_Cnt !== 32'(exp_cnt))
            $display("FAIL mem_hazard_cnt got %0d exp %0d", Stall_Cnt, exp_cnt); else chk_pass++;
    endtask

    task automatic test_mult();
        int unsigned stalls;
        Start_EX = 1'b1; Md_Op_EX = 1'b0; Md_ID = 1'b1;
        #1;
        chk_total++; if (Busy !== 1'b0 || Clr_ID_EX !== 1'b1)
            $display("FAIL mult_start got busy=%0b clr=%0b exp 0/1", Busy, Clr_ID_EX); else chk_pass++;
        stalls = (Clr_ID_EX === 1'b1) ? 1 : 0;
        tick(1);
        Start_EX = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk_total++; if (Busy !== 1'b1 || En_IF_ID !== 1'b0)
                $display("FAIL mult_busy_%0d got busy=%0b en=%0b exp 1/0", i, Busy, En_IF_ID); else chk_pass++;
            if (Clr_ID_EX === 1'b1) stalls++;
            tick(1);
        end
        #1;
        chk_total++; if (Busy !== 1'b0 || En_IF_ID !== 1'b1)
            $display("FAIL mult_done got busy=%0b en=%0b exp 0/1", Busy, En_IF_ID); else chk_pass++;
        chk_total++; if (stalls !== 6) $display("FAIL mult_stall_cycles got %0d exp 6", stalls); else chk_pass++;
        chk_total++; if (Stall_Cnt !== 32'(exp_cnt))
            $display("FAIL mult_cnt got %0d exp %0d", Stall_Cnt, exp_cnt); else chk_pass++;
        clear_inputs();
    endtask

    task automatic test_div();
        Start_EX = 1'b1; Md_Op_EX = 1'b1;
        #1;
        chk_total++; if (Busy !== 1'b0 || Clr_ID_EX !== 1'b0)
            $display("FAIL div_start got busy=%0b clr=%0b exp 0/0", Busy, Clr_ID_EX); else chk_pass++;
        tick(0);
        for (int i = 0; i < 10; i++) begin
            Start_EX = (i == 4);
            #1;
            chk_total++; if (Busy !== 1'b1) $display("FAIL div_busy_%0d got %0b exp 1", i, Busy); else chk_pass++;
            tick(0);
        end
        Start_EX = 1'b0;
        #1;
        chk_total++; if (Busy !== 1'b0) $display("FAIL div_done got %0b exp 0", Busy); else chk_pass++;
        tick(0);
        chk_total++; if (Busy !== 1'b0) $display("FAIL div_no_extend got %0b exp 0", Busy); else chk_pass++;
        clear_inputs();
    endtask

    task automatic test_async_reset();
        Start_EX = 1'b1; Md_Op_EX = 1'b1; Md_ID = 1'b1;
        tick(1);
        Start_EX = 1'b0;
        tick(1);
        tick(1);
        chk_total++; if (Busy !== 1'b1 || Stall_Cnt !== 32'(exp_cnt))
            $display("FAIL pre_reset got busy=%0b cnt=%0d exp 1/%0d", Busy, Stall_Cnt, exp_cnt); else chk_pass++;
        #3;
        reset = 1'b0;
        exp_cnt = 0;
        #1;
        chk_total++; if (Busy !== 1'b0) $display("FAIL async_busy got %0b exp 0", Busy); else chk_pass++;
        chk_total++; if (Stall_Cnt !== 32'd0) $display("FAIL async_cnt got %0d exp 0", Stall_Cnt); else chk_pass++;
        chk_total++; if (En_IF_ID !== 1'b1) $display("FAIL async_md_clear got en=%0b exp 1", En_IF_ID); else chk_pass++;
        #2;
        reset = 1'b1;
        Md_ID = 1'b0;
        tick(0);
        tick(0);
        chk_total++; if (Busy !== 1'b0 || Stall_Cnt !== 32'd0)
            $display("FAIL post_reset got busy=%0b cnt=%0d exp 0/0", Busy, Stall_Cnt); else chk_pass++;
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        Start_EX = 1'b1; Md_Op_EX = 1'b0; Md_ID = 1'b1;
        Rs_ID = 5'd3; A3_EX = 5'd3; Tnew_EX = 2'd2; Tuse_Rs = 2'd0;
        #1;
        chk_total++; if (Clr_ID_EX !== 1'b1) $display("FAIL combo_stall got clr=%0b exp 1", Clr_ID_EX); else chk_pass++;
        tick(1);
        clear_inputs();
        #1;
        chk_total++; if (Stall_Cnt !== 32'(exp_cnt))
            $display("FAIL combo_cnt got %0d exp %0d", Stall_Cnt, exp_cnt); else chk_pass++;
        for (int i = 0; i < 5; i++) tick(0);
        chk_total++; if (Busy !== 1'b0) $display("FAIL combo_idle got %0b exp 0", Busy); else chk_pass++;
    endtask

    task automatic test_saturation();
        int unsigned exp_sat;
        A3_EX = 5'd8; Tnew_EX = 2'd2; Rs_ID = 5'd8; Tuse_Rs = 2'd1;
        for (int i = 0; i < 20; i++) tick(1);
        exp_sat = (exp_cnt > 15) ? 15 : exp_cnt;
        chk_total++; if (s_cnt !== 4'd15 || s_cnt !== 4'(exp_sat))
            $display("FAIL sat_hold got %0d exp %0d", s_cnt, exp_sat); else chk_pass++;
        tick(1);
        chk_total++; if (s_cnt !== 4'd15) $display("FAIL sat_no_wrap got %0d exp 15", s_cnt); else chk_pass++;
        chk_total++; if (Stall_Cnt !== 32'(exp_cnt))
            $display("FAIL sat_wide_cnt got %0d exp %0d", Stall_Cnt, exp_cnt); else chk_pass++;
        clear_inputs();
    endtask

    initial begin
        chk_total = 0;
        chk_pass  = 0;
        exp_cnt   = 0;
        test_reset();
        test_load_use();
        test_zero_unused();
        test_mem_hazard();
        test_mult();
        test_div();
        test_async_reset();
        test_back_to_back();
        test_saturation();
        $display("%0d/%0d checks passed", chk_pass, chk_total);
        $finish;
    end

endmodule
